// File: rtl/int_fmt_pkg.sv
// Shared types and ASCII helpers for the integer-to-ASCII formatter.
package int_fmt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_MEASURE,
        S_PAD_SPACE,
        S_SIGN,
        S_PAD_ZERO,
        S_DIGITS,
        S_SEP
    } state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'd0, nib};
        else
            return ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle.
module bin_to_bcd_seq #(
    parameter int DATA_W = 32,
    localparam int DIGITS = (DATA_W * 30103) / 100000 + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  done
);
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   sh;
    logic [CW-1:0]       cnt;
    logic [DIGITS*4-1:0] bcd;
    logic [DIGITS*4-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
            bcd <= '0;
        end else if (start) begin
            sh  <= bin_in;
            cnt <= CW'(DATA_W);
            bcd <= '0;
        end else if (cnt != '0) begin
            bcd <= {adj[DIGITS*4-2:0], sh[DATA_W-1]};
            sh  <= sh << 1;
            cnt <= cnt - CW'(1);
        end
    end

    // High during the cycle whose closing edge performs the final step.
    assign done    = (cnt == CW'(1));
    assign bcd_out = bcd;

endmodule

// File: rtl/int_to_ascii_fmt.sv
// Formats one integer as a padded decimal/hex ASCII byte stream
// on a valid/ready byte interface.
module int_to_ascii_fmt
    import int_fmt_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FIELD_W_BITS = 5,
    localparam int DEC_DIGITS  = (DATA_W * 30103) / 100000 + 1,
    localparam int HEX_DIGITS  = (DATA_W + 3) / 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value_in,
    input  logic                    signed_mode,
    input  logic                    hex_mode,
    input  logic [FIELD_W_BITS-1:0] field_width,
    input  logic                    zero_pad,
    input  logic                    sep_en,
    input  logic [7:0]              sep_char,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              char_out,
    output logic                    char_valid,
    input  logic                    char_ready
);
    localparam int NDIG = (DEC_DIGITS > HEX_DIGITS) ? DEC_DIGITS : HEX_DIGITS;
    localparam int DV   = NDIG * 4;
    localparam int IW   = $clog2(NDIG + 1);
    localparam int CW   = ((FIELD_W_BITS > IW) ? FIELD_W_BITS : IW) + 1;

    state_t                  state;
    logic                    neg_q, hex_q, zpad_q, sep_q;
    logic [FIELD_W_BITS-1:0] fw_q;
    logic [7:0]              sep_char_q;
    logic [DATA_W-1:0]       mag_q;
    logic [FIELD_W_BITS-1:0] pad_cnt;
    logic [IW-1:0]           dig_idx;

    logic                    accept, neg_in, xfer, bcd_done;
    logic [DATA_W-1:0]       mag_in;
    logic [DEC_DIGITS*4-1:0] bcd_out;
    logic [DV-1:0]           dig_vec;
    logic [IW-1:0]           ndig;
    logic [CW-1:0]           body, fw_ext, pad_w;
    logic [FIELD_W_BITS-1:0] pad_next;

    assign accept = start && (state == S_IDLE);
    assign neg_in = signed_mode && value_in[DATA_W-1];
    assign mag_in = neg_in ? (~value_in + DATA_W'(1)) : value_in;

    bin_to_bcd_seq #(.DATA_W(DATA_W)) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && !hex_mode),
        .bin_in  (mag_in),
        .bcd_out (bcd_out),
        .done    (bcd_done)
    );

    assign dig_vec = hex_q ? DV'(mag_q) : DV'(bcd_out);

    always_comb begin
        ndig = IW'(1);
        for (int i = 0; i < NDIG; i++)
            if (dig_vec[i*4 +: 4] != 4'd0)
                ndig = IW'(i + 1);
    end

    assign body     = CW'(ndig) + CW'(neg_q);
    assign fw_ext   = CW'(fw_q);
    assign pad_w    = (fw_ext > body) ? (fw_ext - body) : '0;
    assign pad_next = pad_w[FIELD_W_BITS-1:0];

    assign busy       = (state != S_IDLE);
    assign char_valid = (state == S_PAD_SPACE) || (state == S_SIGN) ||
                        (state == S_PAD_ZERO)  || (state == S_DIGITS) ||
                        (state == S_SEP);
    assign xfer       = char_valid && char_ready;

    always_comb begin
        char_out = 8'h00;
        unique case (state)
            S_PAD_SPACE: char_out = ASCII_SPACE;
            S_SIGN:      char_out = ASCII_MINUS;
            S_PAD_ZERO:  char_out = ASCII_0;
            S_DIGITS:    char_out = digit_to_ascii(dig_vec[dig_idx*4 +: 4]);
            S_SEP:       char_out = sep_char_q;
            default:     char_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            neg_q      <= 1'b0;
            hex_q      <= 1'b0;
            zpad_q     <= 1'b0;
            sep_q      <= 1'b0;
            fw_q       <= '0;
            sep_char_q <= 8'h00;
            mag_q      <= '0;
            pad_cnt    <= '0;
            dig_idx    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (accept) begin
                    neg_q      <= neg_in;
                    hex_q      <= hex_mode;
                    zpad_q     <= zero_pad;
                    sep_q      <= sep_en;
                    fw_q       <= field_width;
                    sep_char_q <= sep_char;
                    mag_q      <= mag_in;
                    state      <= S_CONVERT;
                end
                S_CONVERT: if (hex_q || bcd_done) state <= S_MEASURE;
                S_MEASURE: begin
                    pad_cnt <= pad_next;
                    dig_idx <= ndig - IW'(1);
                    // Pick the first non-empty phase directly.
                    if (!zpad_q && pad_next != '0) state <= S_PAD_SPACE;
                    else if (neg_q)                 state <= S_SIGN;
                    else if (pad_next != '0)        state <= S_PAD_ZERO;
                    else                            state <= S_DIGITS;
                end
                S_PAD_SPACE: if (xfer) begin
                    pad_cnt <= pad_cnt - FIELD_W_BITS'(1);
                    if (pad_cnt == FIELD_W_BITS'(1))
                        state <= neg_q ? S_SIGN : S_DIGITS;
                end
                S_SIGN: if (xfer)
                    state <= (zpad_q && pad_cnt != '0) ? S_PAD_ZERO : S_DIGITS;
                S_PAD_ZERO: if (xfer) begin
                    pad_cnt <= pad_cnt - FIELD_W_BITS'(1);
                    if (pad_cnt == FIELD_W_BITS'(1)) state <= S_DIGITS;
                end
                S_DIGITS: if (xfer) begin
                    if (dig_idx != '0) begin
                        dig_idx <= dig_idx - IW'(1);
                    end else if (sep_q) begin
                        state <= S_SEP;
                    end else begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_SEP: if (xfer) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/int_to_ascii_fmt.md
Name: int_to_ascii_fmt

Overview:
- Parametrised integer-to-ASCII formatter for the UART/text output path. Converts one DATA_W-bit value into a byte stream on a valid/ready interface.
- Value may be signed or unsigned, rendered in decimal or uppercase hex.
- Optional minimum field width, padded with spaces or zeros.
- Optional trailing separator character, so matrix rows print without an external formatter.

Parameters:
- DATA_W, 32, input value width in bits; legal range 4..64.
- FIELD_W_BITS, 5, width of the field_width input; maximum field width is 2**FIELD_W_BITS-1.
- DEC_DIGITS, (DATA_W*30103)/100000+1, localparam: maximum decimal digits (10 for 32-bit).
- HEX_DIGITS, (DATA_W+3)/4, localparam: maximum hex digits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- value_in  in  DATA_W  value to format; captured when start is accepted.
- signed_mode  in  1  1 = two's-complement value, 0 = unsigned; captured at start.
- hex_mode  in  1  1 = hex (0-9, A-F, no prefix), 0 = decimal; captured at start.
- field_width  in  FIELD_W_BITS  minimum total characters excluding the separator; 0 = no padding; captured at start.
- zero_pad  in  1  1 = pad with '0' after the sign, 0 = pad with ' ' before the sign; captured at start.
- sep_en  in  1  1 = append sep_char after the digits; captured at start.
- sep_char  in  8  separator byte; captured at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last byte handshake.
- char_out  out  8  current byte.
- char_valid  out  1  byte valid.
- char_ready  in  1  sink ready; a transfer occurs when char_valid && char_ready.

Behaviour:
- Reset values: busy=0, done=0, char_valid=0, char_out=8'h00, state=IDLE, all captured fields cleared. Reset mid-stream aborts immediately; char_valid drops asynchronously and no done pulse is issued.
- start outside IDLE is ignored with no queuing.
- Magnitude: if signed_mode and value_in[DATA_W-1]=1, neg=1 and mag = two's-complement negation as unsigned DATA_W bits. The most negative value yields 2**(DATA_W-1) exactly. Otherwise neg=0 and mag=value_in.
- States: IDLE -> CONVERT -> MEASURE -> PAD_SPACE -> SIGN -> PAD_ZERO -> DIGITS -> SEP -> IDLE. Empty phases are skipped in zero cycles, i.e. the next state is chosen directly.
- CONVERT, decimal: shift-add-3 (double dabble), exactly DATA_W cycles.
- CONVERT, hex: 1 cycle; nibbles are taken directly and the top nibble is zero-extended.
- MEASURE (1 cycle):
  - ndig = index of the most significant non-zero digit + 1, minimum 1 (zero prints "0").
  - body = ndig + neg.
  - pad = field_width - body if field_width > body, else 0.
- Timing: start sampled at cycle 0. First char_valid is at cycle DATA_W+2 in decimal and cycle 3 in hex.
- Emission order:
  - zero_pad=0: pad spaces, then '-' if neg, then digits MSD first, then sep_char if sep_en.
  - zero_pad=1: '-' if neg, then pad '0's, then digits, then sep_char.
- Handshake:
  - One byte per accepted transfer; full throughput is one byte per cycle while char_ready=1.
  - char_out is stable while char_valid=1 and char_ready=0. char_valid never drops without a transfer, except on reset.
  - char_out = 8'h00 when char_valid=0.
- Completion: on the final transfer the state returns to IDLE. In the next cycle done=1 and busy=0, and start may be accepted in that same cycle.
- Output length is at most max(field_width, DEC_DIGITS+1) + 1 bytes. The pad counter has FIELD_W_BITS bits and must not wrap.

Decomposition:
- int_fmt_pkg holds:
  - the state_t enum;
  - ASCII constants (ASCII_0, ASCII_A, ASCII_MINUS, ASCII_SPACE);
  - a function digit_to_ascii(nibble) returning '0'-'9' or 'A'-'F'.
- bin_to_bcd_seq is a sequential double-dabble sub-module with parameter DATA_W and ports start/bin_in/bcd_out/done. It is instantiated only for the decimal path; the hex path bypasses it.

Test Plan:
- DATA_W=32, signed, decimal, value -12345, field_width=0, sep_en=0, char_ready=1 -> bytes "-12345", first valid 34 cycles after start, done pulse once.
- value 32'h80000000, signed, decimal -> "-2147483648"; same bits with signed_mode=0 -> "2147483648".
- value 0, decimal, field_width=4, zero_pad=0, sep_en=1, sep_char=',' -> "   0,"; value -7, field_width=4, zero_pad=1 -> "-007".
- hex_mode=1, value 32'h00BEEF01, unsigned -> "BEEF01", first valid 3 cycles after start; DATA_W=8 build, value 8'hFF signed decimal -> "-1".
- Random char_ready backpressure on 1000 random values/modes -> byte stream matches $sformatf model; char_out stable while stalled; start during busy ignored.
- Assert rst_n low mid-DIGITS -> char_valid=0 and busy=0 immediately, no done pulse; a subsequent start of 42 outputs "42".
